// File: rtl/gray_serial_decoder.sv
// Bit-serial Gray-to-binary receiver: MSB-first Gray bits in, decoded word out on valid/ready.
// Define GRAY_DEC_PARITY_EN to append an even-parity bit to each frame (N+1 bits per frame).
module gray_serial_decoder #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         in_valid,
  input  logic         in_bit,
  input  logic         in_sof,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [N-1:0] out_gray,
  output logic         busy,
  output logic         frame_err,
  output logic         par_err
);

  localparam int unsigned CW = $clog2(N + 2);

  typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          acc;
  logic [N-1:0]  gray_sr;
  logic [N-1:0]  data_sr;
  logic          take;

  assign in_ready = en && !rst && (state != HOLD);
  assign take     = in_valid && in_ready;
  assign out_gray = gray_sr;
  assign out_data = data_sr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      acc       <= 1'b0;
      gray_sr   <= '0;
      data_sr   <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
      par_err   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      par_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (take) begin
            if (in_sof) begin
              state   <= SHIFT;
              busy    <= 1'b1;
              acc     <= in_bit;
              gray_sr <= {{(N-1){1'b0}}, in_bit};
              data_sr <= {{(N-1){1'b0}}, in_bit};
              cnt     <= CW'(1);
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (!en) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else if (take) begin
            if (in_sof) begin
              // Resync: the stray start bit becomes bit 0 of a fresh frame.
              frame_err <= 1'b1;
              acc       <= in_bit;
              gray_sr   <= {{(N-1){1'b0}}, in_bit};
              data_sr   <= {{(N-1){1'b0}}, in_bit};
              cnt       <= CW'(1);
`ifdef GRAY_DEC_PARITY_EN
            end else if (cnt == CW'(N)) begin
              busy <= 1'b0;
              cnt  <= '0;
              if (in_bit == ^gray_sr) begin
                state     <= HOLD;
                out_valid <= 1'b1;
              end else begin
                state   <= IDLE;
                par_err <= 1'b1;
              end
`endif
            end else begin
              acc     <= acc ^ in_bit;
              gray_sr <= {gray_sr[N-2:0], in_bit};
              data_sr <= {data_sr[N-2:0], acc ^ in_bit};
              cnt     <= cnt + CW'(1);
`ifndef GRAY_DEC_PARITY_EN
              if (cnt == CW'(N - 1)) begin
                state     <= HOLD;
                out_valid <= 1'b1;
                busy      <= 1'b0;
              end
`endif
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            cnt       <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          cnt       <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gray_serial_decoder.sv
// Directed self-checking bench for gray_serial_decoder (N=8); parity scenarios build
// only when GRAY_DEC_PARITY_EN is defined.
module tb_gray_serial_decoder;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst, en, in_valid, in_bit, in_sof, out_ready;
  logic         in_ready, out_valid, busy, frame_err, par_err;
  logic [N-1:0] out_data, out_gray;

  int passed = 0;
  int total  = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;

  gray_serial_decoder #(.N(N)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_bit(in_bit),
    .in_sof(in_sof), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_gray(out_gray),
    .busy(busy), .frame_err(frame_err), .par_err(par_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one bit, waiting (bounded) for in_ready, then sample just after the edge.
  task automatic send_bit(input logic b, input logic sof);
    int unsigned waitc = 0;
    in_valid = 1'b1; in_bit = b; in_sof = sof;
    #1;
    while (!in_ready && waitc < 20) begin
      @(posedge clk); #1;
      waitc++;
    end
    if (!in_ready) begin
      total++;
      $display("FAIL send_bit_timeout: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    ferr_cnt += int'(frame_err);
    perr_cnt += int'(par_err);
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  task automatic send_gray(input logic [N-1:0] g);
    for (int i = N - 1; i >= 0; i--) send_bit(g[i], i == N - 1);
  endtask

  task automatic send_word(input logic [N-1:0] g);
    send_gray(g);
`ifdef GRAY_DEC_PARITY_EN
    send_bit(^g, 1'b0);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; in_bit = 1'b0; in_sof = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready: got %b required 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b required 0", out_valid); else passed++;
    total++; if (out_data !== 8'h00) $display("FAIL rst_out_data: got %h required 00", out_data); else passed++;
    total++; if (out_gray !== 8'h00) $display("FAIL rst_out_gray: got %h required 00", out_gray); else passed++;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else passed++;
    total++; if (frame_err !== 1'b0 || par_err !== 1'b0)
      $display("FAIL rst_errs: got %b%b required 00", frame_err, par_err); else passed++;
    rst = 1'b0; #1;
    total++; if (in_ready !== 1'b1) $display("FAIL post_rst_in_ready: got %b required 1", in_ready); else passed++;
  endtask

  task automatic test_basic;
    out_ready = 1'b1; ferr_cnt = 0; perr_cnt = 0;
    send_word(8'hC5);
    total++; if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b required 1", out_valid); else passed++;
    total++; if (out_data !== 8'h86) $display("FAIL basic_data: got %h required 86", out_data); else passed++;
    total++; if (out_gray !== 8'hC5) $display("FAIL basic_gray: got %h required c5", out_gray); else passed++;
    total++; if (busy !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL basic_hold_flags: busy=%b in_ready=%b required 0 0", busy, in_ready); else passed++;
    total++; if (ferr_cnt != 0 || perr_cnt != 0)
      $display("FAIL basic_errs: frame=%0d par=%0d required 0 0", ferr_cnt, perr_cnt); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL basic_release: valid=%b in_ready=%b required 0 1", out_valid, in_ready); else passed++;
  endtask

  task automatic test_hold;
    out_ready = 1'b0;
    send_word(8'h80);
    in_valid = 1'b1; in_bit = 1'b1; in_sof = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++; if (out_valid !== 1'b1 || out_data !== 8'hFF || in_ready !== 1'b0)
        $display("FAIL hold_cycle%0d: valid=%b data=%h in_ready=%b required 1 ff 0", i, out_valid, out_data, in_ready);
      else passed++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_sof = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL hold_release: got %b required 0", out_valid); else passed++;
    send_word(8'h00);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h00)
      $display("FAIL hold_next: valid=%b data=%h required 1 00", out_valid, out_data); else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_resync;
    out_ready = 1'b1; ferr_cnt = 0;
    send_bit(1'b1, 1'b1); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
    send_word(8'h01);
    total++; if (ferr_cnt != 1) $display("FAIL resync_ferr: got %0d pulses required 1", ferr_cnt); else passed++;
    total++; if (out_valid !== 1'b1 || out_data !== 8'h01 || out_gray !== 8'h01)
      $display("FAIL resync_word: valid=%b data=%h gray=%h required 1 01 01", out_valid, out_data, out_gray);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_stray;
    send_bit(1'b1, 1'b0);
    total++; if (frame_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL stray_pulse: ferr=%b valid=%b busy=%b required 1 0 0", frame_err, out_valid, busy);
    else passed++;
    @(posedge clk); #1;
    total++; if (frame_err !== 1'b0) $display("FAIL stray_one_cycle: got %b required 0", frame_err); else passed++;
  endtask

  task automatic test_en_drop;
    ferr_cnt = 0;
    send_bit(1'b0, 1'b1); send_bit(1'b1, 1'b0); send_bit(1'b1, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL en_busy: got %b required 1", busy); else passed++;
    en = 1'b0; in_valid = 1'b1; in_bit = 1'b1; #1;
    total++; if (in_ready !== 1'b0) $display("FAIL en_in_ready: got %b required 0", in_ready); else passed++;
    @(posedge clk); #1;
    total++; if (busy !== 1'b0 || frame_err !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL en_abort: busy=%b ferr=%b valid=%b required 0 0 0", busy, frame_err, out_valid);
    else passed++;
    in_valid = 1'b0; en = 1'b1;
    send_word(8'h5A);
    total++; if (ferr_cnt != 0 || out_valid !== 1'b1 || out_data !== 8'h6C)
      $display("FAIL en_next: ferr=%0d valid=%b data=%h required 0 1 6c", ferr_cnt, out_valid, out_data);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    send_word(8'hC5);
    total++; if (out_data !== 8'h86) $display("FAIL b2b_first: got %h required 86", out_data); else passed++;
    send_word(8'h80);
    total++; if (out_valid !== 1'b1 || out_data !== 8'hFF)
      $display("FAIL b2b_second: valid=%b data=%h required 1 ff", out_valid, out_data); else passed++;
    @(posedge clk); #1;
  endtask

`ifdef GRAY_DEC_PARITY_EN
  task automatic test_parity;
    out_ready = 1'b1; perr_cnt = 0;
    send_gray(8'hC5); send_bit(1'b0, 1'b0);
    total++; if (out_valid !== 1'b1 || out_data !== 8'h86 || perr_cnt != 0)
      $display("FAIL par_good: valid=%b data=%h perr=%0d required 1 86 0", out_valid, out_data, perr_cnt);
    else passed++;
    @(posedge clk); #1;
    send_gray(8'hC5); send_bit(1'b1, 1'b0);
    total++; if (par_err !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL par_bad: perr=%b valid=%b busy=%b required 1 0 0", par_err, out_valid, busy);
    else passed++;
    @(posedge clk); #1;
    total++; if (par_err !== 1'b0 || out_valid !== 1'b0)
      $display("FAIL par_after: perr=%b valid=%b required 0 0", par_err, out_valid); else passed++;
  endtask
`endif

  task automatic test_rst_hold;
    out_ready = 1'b0;
    send_word(8'hC5);
    total++; if (out_valid !== 1'b1) $display("FAIL rsthold_valid: got %b required 1", out_valid); else passed++;
    rst = 1'b1;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0 || out_data !== 8'h00 || out_gray !== 8'h00 || busy !== 1'b0)
      $display("FAIL rsthold_cleared: valid=%b data=%h gray=%h busy=%b required 0 00 00 0",
               out_valid, out_data, out_gray, busy);
    else passed++;
    rst = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_hold;
    test_resync;
    test_idle_stray;
    test_en_drop;
    test_back_to_back;
`ifdef GRAY_DEC_PARITY_EN
    test_parity;
`endif
    test_rst_hold;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
